// File: rtl/yc422_embsync_tx.sv
// 4:4:4 to 4:2:2 Y/C transmitter with embedded EAV/SAV timing codes.
// Two-stage pipeline: classify and register, then chroma/clip/code mux.
module yc422_embsync_tx #(
    parameter int PERIOD_X = 864,
    parameter int ACTIVE_W = 720,
    parameter int ACTIVE_H = 576
) (
    input  logic        pixelclk_is,
    input  logic        reset_is,
    input  logic [9:0]  YSTART_IM,
    input  logic [9:0]  XSTART_IM,
    input  logic [9:0]  ycount_im,
    input  logic [9:0]  xcount_im,
    input  logic [7:0]  Y_data_im,
    input  logic [7:0]  U_data_im,
    input  logic [7:0]  V_data_im,
    output logic [15:0] yc_data_om,
    output logic        de_om,
    output logic        sof_om,
    output logic [9:0]  xcount_om,
    output logic [9:0]  ycount_om
);

    localparam logic [10:0] PX = 11'(PERIOD_X);
    localparam logic [10:0] AW = 11'(ACTIVE_W);
    localparam logic [10:0] AH = 11'(ACTIVE_H);

    typedef enum logic [1:0] {
        CL_BLANK,
        CL_ACTIVE,
        CL_SAV,
        CL_EAV
    } cls_t;

    logic       win_latch;
    logic [9:0] xs_q, ys_q, xs, ys;

    assign win_latch = (xcount_im == 10'd0) && (ycount_im == 10'd0);

    // Window moves only at frame start; the latch cycle already sees it.
    assign xs = win_latch ? XSTART_IM : xs_q;
    assign ys = win_latch ? YSTART_IM : ys_q;

    always_ff @(posedge pixelclk_is) begin
        if (reset_is || win_latch) begin
            xs_q <= XSTART_IM;
            ys_q <= YSTART_IM;
        end
    end

    logic [10:0] x11, y11, xs11, ys11, xend, yend;
    logic        in_v, in_h, is_sav, is_eav;
    cls_t        cls;
    logic [1:0]  k;

    assign x11  = {1'b0, xcount_im};
    assign y11  = {1'b0, ycount_im};
    assign xs11 = {1'b0, xs};
    assign ys11 = {1'b0, ys};
    assign xend = xs11 + AW;
    assign yend = ys11 + AH;

    assign in_v   = (y11 >= ys11) && (y11 < yend);
    assign in_h   = (x11 >= xs11) && (x11 < xend);
    assign is_sav = (x11 + 11'd4 >= xs11) && (x11 < xs11);
    assign is_eav = (x11 >= xend) && (x11 <= xend + 11'd3)
                 && (xend + 11'd3 < PX);

    always_comb begin
        cls = CL_BLANK;
        k   = 2'd0;
        if (in_v && in_h) begin
            cls = CL_ACTIVE;
        end else if (is_sav) begin
            cls = CL_SAV;
            k   = 2'(x11 + 11'd4 - xs11);
        end else if (is_eav) begin
            cls = CL_EAV;
            k   = 2'(x11 - xend);
        end
    end

    cls_t       s1_cls;
    logic [1:0] s1_k;
    logic       s1_vb, s1_sof, s1_odd;
    logic [7:0] s1_y, s1_u, s1_v, hold_v;
    logic [9:0] s1_x, s1_yc;

    always_ff @(posedge pixelclk_is) begin
        if (reset_is) begin
            s1_cls <= CL_BLANK;
            s1_k   <= 2'd0;
            s1_vb  <= 1'b0;
            s1_sof <= 1'b0;
            s1_odd <= 1'b0;
            s1_y   <= 8'd0;
            s1_u   <= 8'd0;
            s1_v   <= 8'd0;
            s1_x   <= 10'd0;
            s1_yc  <= 10'd0;
            hold_v <= 8'd0;
        end else begin
            s1_cls <= cls;
            s1_k   <= k;
            s1_vb  <= !in_v;
            s1_sof <= (cls == CL_SAV) && (k == 2'd0) && (y11 == ys11);
            s1_odd <= xcount_im[0] ^ xs[0];
            s1_y   <= Y_data_im;
            s1_u   <= U_data_im;
            s1_v   <= V_data_im;
            s1_x   <= xcount_im;
            s1_yc  <= ycount_im;
            hold_v <= s1_v;
        end
    end

    function automatic logic [7:0] clip(input logic [7:0] d);
        if (d == 8'h00) return 8'h01;
        if (d == 8'hFF) return 8'hFE;
        return d;
    endfunction

    logic [7:0] cb, cr, c_raw, xy, code;
    logic       h;

    // Cb pairs stage-1 sample with live look-ahead; Cr with held V.
    assign cb = 8'(({1'b0, s1_u} + {1'b0, U_data_im} + 9'd1) >> 1);
    assign cr = 8'(({1'b0, hold_v} + {1'b0, s1_v} + 9'd1) >> 1);
    assign c_raw = s1_odd ? cr : cb;
    assign h  = (s1_cls == CL_EAV);
    assign xy = {1'b1, 1'b0, s1_vb, h, s1_vb ^ h, h, s1_vb, s1_vb ^ h};

    always_comb begin
        code = 8'h00;
        unique case (s1_k)
            2'd0: code = 8'hFF;
            2'd1: code = 8'h00;
            2'd2: code = 8'h00;
            2'd3: code = xy;
        endcase
    end

    always_ff @(posedge pixelclk_is) begin
        if (reset_is) begin
            yc_data_om <= 16'h1080;
            de_om      <= 1'b0;
            sof_om     <= 1'b0;
            xcount_om  <= 10'd0;
            ycount_om  <= 10'd0;
        end else begin
            de_om      <= (s1_cls == CL_ACTIVE);
            sof_om     <= s1_sof;
            xcount_om  <= s1_x;
            ycount_om  <= s1_yc;
            unique case (s1_cls)
                CL_ACTIVE: yc_data_om <= {clip(s1_y), clip(c_raw)};
                CL_SAV:    yc_data_om <= {code, code};
                CL_EAV:    yc_data_om <= {code, code};
                CL_BLANK:  yc_data_om <= 16'h1080;
            endcase
        end
    end

endmodule

// File: tb/tb_yc422_embsync_tx.sv
// Directed vector bench for yc422_embsync_tx; each record is one input
// sample, checked against the output two clocks later.
module tb_yc422_embsync_tx;

    logic        pixelclk_is = 1'b0;
    logic        reset_is;
    logic [9:0]  YSTART_IM, XSTART_IM, ycount_im, xcount_im;
    logic [7:0]  Y_data_im, U_data_im, V_data_im;
    logic [15:0] yc_data_om;
    logic        de_om, sof_om;
    logic [9:0]  xcount_om, ycount_om;

    yc422_embsync_tx dut (
        .pixelclk_is (pixelclk_is),
        .reset_is    (reset_is),
        .YSTART_IM   (YSTART_IM),
        .XSTART_IM   (XSTART_IM),
        .ycount_im   (ycount_im),
        .xcount_im   (xcount_im),
        .Y_data_im   (Y_data_im),
        .U_data_im   (U_data_im),
        .V_data_im   (V_data_im),
        .yc_data_om  (yc_data_om),
        .de_om       (de_om),
        .sof_om      (sof_om),
        .xcount_om   (xcount_om),
        .ycount_om   (ycount_om)
    );

    always #5 pixelclk_is = ~pixelclk_is;

    typedef struct {
        logic [9:0]  xs;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [7:0]  yd;
        logic [7:0]  u;
        logic [7:0]  v;
        logic        rst;
        logic [15:0] w;
        logic        de;
        logic        sof;
        int          chk;
    } vec_t;

    vec_t tbl[$];
    vec_t prev;
    vec_t rst_out;
    bit   have_prev;
    int   prev_id;
    int   n_chk;
    int   n_fail;

    function automatic vec_t mk(
        input logic [9:0] xs, input logic [9:0] x, input logic [9:0] y,
        input logic [7:0] yd, input logic [7:0] u, input logic [7:0] v,
        input logic rst, input logic [15:0] w, input logic de,
        input logic sof, input int chk);
        vec_t r;
        r.xs = xs; r.x = x; r.y = y;
        r.yd = yd; r.u = u; r.v = v;
        r.rst = rst; r.w = w; r.de = de; r.sof = sof; r.chk = chk;
        return r;
    endfunction

    // Flat grey sample with expected word/de/sof.
    function automatic vec_t fl(
        input logic [9:0] xs, input logic [9:0] x, input logic [9:0] y,
        input logic [15:0] w, input logic de, input logic sof);
        return mk(xs, x, y, 8'h80, 8'h40, 8'hC0, 1'b0, w, de, sof, 1);
    endfunction

    task automatic check(input vec_t e, input int id);
        logic bad;
        n_chk++;
        bad = (e.chk == 2) ? (yc_data_om[15:8] !== e.w[15:8])
                           : (yc_data_om !== e.w);
        if (bad) begin
            n_fail++;
            $display("FAIL vec%0d data: got %h want %h",
                     id, yc_data_om, e.w);
        end
        n_chk++;
        if (de_om !== e.de) begin
            n_fail++;
            $display("FAIL vec%0d de: got %b want %b", id, de_om, e.de);
        end
        n_chk++;
        if (sof_om !== e.sof) begin
            n_fail++;
            $display("FAIL vec%0d sof: got %b want %b", id, sof_om, e.sof);
        end
        n_chk++;
        if ({xcount_om, ycount_om} !== {e.x, e.y}) begin
            n_fail++;
            $display("FAIL vec%0d count: got x%0d y%0d want x%0d y%0d",
                     id, xcount_om, ycount_om, e.x, e.y);
        end
    endtask

    task automatic step(input vec_t v, input int id);
        XSTART_IM = v.xs;
        YSTART_IM = 10'd24;
        xcount_im = v.x;
        ycount_im = v.y;
        Y_data_im = v.yd;
        U_data_im = v.u;
        V_data_im = v.v;
        reset_is  = v.rst;
        @(posedge pixelclk_is);
        #1;
        if (v.rst) check(rst_out, id);
        else if (have_prev) check(prev, prev_id);
        prev      = v.rst ? rst_out : v;
        prev_id   = id;
        have_prev = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        have_prev = 1'b0;
        prev_id = 0;
        rst_out = mk(10'd132, 10'd0, 10'd0, 8'h0, 8'h0, 8'h0,
                     1'b0, 16'h1080, 1'b0, 1'b0, 1);

        // Reset
        tbl.push_back(mk(132, 0, 0, 8'h80, 8'h40, 8'hC0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(132, 0, 0, 8'h80, 8'h40, 8'hC0, 1, 0, 0, 0, 1));
        // First active line: SAV, active, EAV
        tbl.push_back(fl(132, 128, 24, 16'hFFFF, 0, 1));
        tbl.push_back(fl(132, 129, 24, 16'h0000, 0, 0));
        tbl.push_back(fl(132, 130, 24, 16'h0000, 0, 0));
        tbl.push_back(fl(132, 131, 24, 16'h8080, 0, 0));
        tbl.push_back(fl(132, 132, 24, 16'h8040, 1, 0));
        tbl.push_back(fl(132, 133, 24, 16'h80C0, 1, 0));
        tbl.push_back(fl(132, 134, 24, 16'h8040, 1, 0));
        tbl.push_back(fl(132, 850, 24, 16'h8040, 1, 0));
        tbl.push_back(fl(132, 851, 24, 16'h80C0, 1, 0));
        tbl.push_back(fl(132, 852, 24, 16'hFFFF, 0, 0));
        tbl.push_back(fl(132, 853, 24, 16'h0000, 0, 0));
        tbl.push_back(fl(132, 854, 24, 16'h0000, 0, 0));
        tbl.push_back(fl(132, 855, 24, 16'h9D9D, 0, 0));
        tbl.push_back(fl(132, 856, 24, 16'h1080, 0, 0));
        tbl.push_back(fl(132, 128, 25, 16'hFFFF, 0, 0));
        // Vertical edges
        tbl.push_back(fl(132, 851, 599, 16'h80C0, 1, 0));
        tbl.push_back(fl(132, 200, 600, 16'h1080, 0, 0));
        tbl.push_back(fl(132, 131, 600, 16'hABAB, 0, 0));
        // Blanking line 0
        tbl.push_back(fl(132, 128, 0, 16'hFFFF, 0, 0));
        tbl.push_back(fl(132, 129, 0, 16'h0000, 0, 0));
        tbl.push_back(fl(132, 130, 0, 16'h0000, 0, 0));
        tbl.push_back(fl(132, 131, 0, 16'hABAB, 0, 0));
        tbl.push_back(fl(132, 132, 0, 16'h1080, 0, 0));
        tbl.push_back(fl(132, 852, 0, 16'hFFFF, 0, 0));
        tbl.push_back(fl(132, 853, 0, 16'h0000, 0, 0));
        tbl.push_back(fl(132, 854, 0, 16'h0000, 0, 0));
        tbl.push_back(fl(132, 855, 0, 16'hB6B6, 0, 0));
        tbl.push_back(fl(132, 856, 0, 16'h1080, 0, 0));
        tbl.push_back(fl(132, 131, 23, 16'hABAB, 0, 0));
        // Chroma averaging
        tbl.push_back(mk(132, 200, 30, 8'h50, 8'h10, 8'h20,
                         0, 16'h5011, 1, 0, 1));
        tbl.push_back(mk(132, 201, 30, 8'h50, 8'h11, 8'h23,
                         0, 16'h5022, 1, 0, 1));
        // Clipping
        tbl.push_back(mk(132, 300, 31, 8'h00, 8'hFF, 8'hFF,
                         0, 16'h01FE, 1, 0, 1));
        tbl.push_back(mk(132, 301, 31, 8'hFF, 8'hFF, 8'hFF,
                         0, 16'hFEFE, 1, 0, 1));
        tbl.push_back(mk(132, 302, 31, 8'h00, 8'hFF, 8'hFF,
                         0, 16'h01A0, 1, 0, 1));
        // Reset mid-line at line 50
        tbl.push_back(fl(132, 296, 50, 16'h8040, 1, 0));
        tbl.push_back(fl(132, 297, 50, 16'h80C0, 1, 0));
        tbl.push_back(fl(132, 298, 50, 16'h8040, 1, 0));
        tbl.push_back(fl(132, 299, 50, 16'h80C0, 1, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(132, 10'(300 + i), 50, 8'h80, 8'h40, 8'hC0,
                             1, 0, 0, 0, 1));
        tbl.push_back(mk(132, 303, 50, 8'h80, 8'h40, 8'hC0,
                         0, 16'h8000, 1, 0, 2));
        tbl.push_back(fl(132, 304, 50, 16'h8040, 1, 0));
        tbl.push_back(fl(132, 305, 50, 16'h80C0, 1, 0));
        tbl.push_back(fl(132, 128, 51, 16'hFFFF, 0, 0));
        tbl.push_back(fl(132, 129, 51, 16'h0000, 0, 0));
        tbl.push_back(fl(132, 130, 51, 16'h0000, 0, 0));
        tbl.push_back(fl(132, 131, 51, 16'h8080, 0, 0));
        tbl.push_back(fl(132, 852, 51, 16'hFFFF, 0, 0));
        tbl.push_back(fl(132, 853, 51, 16'h0000, 0, 0));
        tbl.push_back(fl(132, 854, 51, 16'h0000, 0, 0));
        tbl.push_back(fl(132, 855, 51, 16'h9D9D, 0, 0));
        // Window change mid-frame: old window holds until frame start
        tbl.push_back(fl(140, 128, 100, 16'hFFFF, 0, 0));
        tbl.push_back(fl(140, 136, 101, 16'h8040, 1, 0));
        tbl.push_back(fl(140, 0, 0, 16'h1080, 0, 0));
        tbl.push_back(fl(140, 135, 0, 16'h1080, 0, 0));
        tbl.push_back(fl(140, 136, 0, 16'hFFFF, 0, 0));
        tbl.push_back(fl(140, 137, 0, 16'h0000, 0, 0));
        tbl.push_back(fl(140, 138, 0, 16'h0000, 0, 0));
        tbl.push_back(fl(140, 139, 0, 16'hABAB, 0, 0));
        tbl.push_back(fl(140, 859, 0, 16'h1080, 0, 0));
        tbl.push_back(fl(140, 860, 0, 16'hFFFF, 0, 0));
        tbl.push_back(fl(140, 861, 0, 16'h0000, 0, 0));
        tbl.push_back(fl(140, 862, 0, 16'h0000, 0, 0));
        tbl.push_back(fl(140, 863, 0, 16'hB6B6, 0, 0));
        tbl.push_back(fl(140, 136, 24, 16'hFFFF, 0, 1));
        tbl.push_back(fl(140, 139, 24, 16'h8080, 0, 0));
        tbl.push_back(fl(140, 140, 24, 16'h8040, 1, 0));
        // EAV would cross the line end: suppressed
        tbl.push_back(fl(142, 0, 0, 16'h1080, 0, 0));
        tbl.push_back(fl(142, 862, 0, 16'h1080, 0, 0));
        tbl.push_back(fl(142, 863, 0, 16'h1080, 0, 0));
        tbl.push_back(fl(142, 138, 0, 16'hFFFF, 0, 0));
        // Flush
        tbl.push_back(fl(142, 5, 1, 16'h1080, 0, 0));

        foreach (tbl[i]) step(tbl[i], i);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
